flit_sink: RTL and testbench

Packet receiver and checker for the output side of the NoC mux (`odata`/`ovalid`/`ovch`) during power characterization runs. It accepts HEAD/DATA/TAIL flits and checks packet framing and virtual-channel consistency. It reports one completion record per packet and accumulates flit, packet, error and payload bit-toggle counts, which the characterization flow reads in place of VCD post-processing. There is no backpressure: every valid flit is consumed in the cycle it is sampled.

---
 rtl/flit_sink.sv | 197 +++++++++++++++++++
 tb/tb_flit_sink.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/flit_sink.sv
// Packet receiver/checker for the NoC mux output: validates HEAD/DATA/TAIL framing and VC
// consistency, emits one completion record per packet and keeps flit/packet/error/toggle counts.
module flit_sink #(
  parameter int DATAW  = 64,
  parameter int TYPEW  = 2,
  parameter int VCHW   = 1,
  parameter int MAXLEN = 32,
  parameter int CNTW   = 16,
  parameter int ACCW   = 32
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [TYPEW+DATAW-1:0] idata,
  input  logic                   ivalid,
  input  logic [VCHW-1:0]        ivch,
  input  logic                   clr,
  output logic                   busy,
  output logic                   pkt_done,
  output logic [7:0]             pkt_len,
  output logic [VCHW-1:0]        pkt_vch,
  output logic                   pkt_err,
  output logic [2:0]             err_code,
  output logic [CNTW-1:0]        pkt_cnt,
  output logic [CNTW-1:0]        err_cnt,
  output logic [CNTW-1:0]        flit_cnt,
  output logic [ACCW-1:0]        toggle_acc
);

  localparam int PCW = $clog2(DATAW + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BODY = 1'b1;

  localparam logic [TYPEW-1:0] T_NONE = 2'd0;
  localparam logic [TYPEW-1:0] T_HEAD = 2'd1;
  localparam logic [TYPEW-1:0] T_DATA = 2'd2;
  localparam logic [TYPEW-1:0] T_TAIL = 2'd3;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_ORPHAN  = 3'd1;
  localparam logic [2:0] E_NESTED  = 3'd2;
  localparam logic [2:0] E_VCH     = 3'd3;
  localparam logic [2:0] E_OVERLEN = 3'd4;

  localparam logic [7:0]      MAXLEN_L = 8'(MAXLEN);
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  function automatic logic [PCW-1:0] popcount(input logic [DATAW-1:0] v);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i < DATAW; i++) c = c + PCW'(v[i]);
    return c;
  endfunction

  logic [0:0]       state_r, state_nxt_s;
  logic [7:0]       len_r, len_nxt_s;
  logic [VCHW-1:0]  vch_r, vch_nxt_s;
  logic [2:0]       err_r, err_nxt_s;
  logic [DATAW-1:0] prev_r;

  logic [TYPEW-1:0] ftype_s;
  logic [DATAW-1:0] payload_s;
  logic             accept_s;
  logic             vch_mis_s;
  logic [2:0]       data_err_s;
  logic             rec_s;
  logic [7:0]       rec_len_s;
  logic [VCHW-1:0]  rec_vch_s;
  logic [2:0]       rec_err_s;
  logic [ACCW:0]    tsum_s;

  assign ftype_s    = idata[TYPEW+DATAW-1:DATAW];
  assign payload_s  = idata[DATAW-1:0];
  assign accept_s   = ivalid && (ftype_s != T_NONE);
  assign vch_mis_s  = (ivch != vch_r);
  assign data_err_s = vch_mis_s ? E_VCH : ((len_r == MAXLEN_L) ? E_OVERLEN : E_NONE);
  assign tsum_s     = {1'b0, toggle_acc} + (ACCW+1)'(popcount(payload_s ^ prev_r));

  // Next-state and completion-record decode for the accepted flit.
  always_comb begin
    state_nxt_s = state_r;
    len_nxt_s   = len_r;
    vch_nxt_s   = vch_r;
    err_nxt_s   = err_r;
    rec_s       = 1'b0;
    rec_len_s   = 8'd0;
    rec_vch_s   = ivch;
    rec_err_s   = E_NONE;
    if (accept_s) begin
      case (state_r)
        IDLE: begin
          if (ftype_s == T_HEAD) begin
            state_nxt_s = BODY;
            vch_nxt_s   = ivch;
            len_nxt_s   = 8'd0;
            err_nxt_s   = E_NONE;
          end else begin
            rec_s     = 1'b1;
            rec_err_s = E_ORPHAN;
          end
        end
        BODY: begin
          case (ftype_s)
            T_HEAD: begin
              // A fresh HEAD closes the open packet and immediately starts the next one.
              rec_s     = 1'b1;
              rec_len_s = len_r;
              rec_vch_s = vch_r;
              rec_err_s = (err_r != E_NONE) ? err_r : E_NESTED;
              vch_nxt_s = ivch;
              len_nxt_s = 8'd0;
              err_nxt_s = E_NONE;
            end
            T_DATA: begin
              len_nxt_s = (len_r == MAXLEN_L) ? len_r : (len_r + 8'd1);
              err_nxt_s = (err_r != E_NONE) ? err_r : data_err_s;
            end
            T_TAIL: begin
              state_nxt_s = IDLE;
              rec_s       = 1'b1;
              rec_len_s   = len_r;
              rec_vch_s   = vch_r;
              rec_err_s   = (err_r != E_NONE) ? err_r : (vch_mis_s ? E_VCH : E_NONE);
            end
            default: begin
              state_nxt_s = state_r;
            end
          endcase
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Packet FSM, per-packet latches and the previous payload used for toggle counting.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_r <= IDLE;
      len_r   <= 8'd0;
      vch_r   <= '0;
      err_r   <= E_NONE;
      prev_r  <= '0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      len_r   <= len_nxt_s;
      vch_r   <= vch_nxt_s;
      err_r   <= err_nxt_s;
      prev_r  <= accept_s ? payload_s : prev_r;
      busy    <= (state_r == BODY) || (state_nxt_s == BODY);
    end
  end

  // Completion record: one-cycle pulse, fields held until the next record.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pkt_done <= 1'b0;
      pkt_len  <= 8'd0;
      pkt_vch  <= '0;
      pkt_err  <= 1'b0;
      err_code <= E_NONE;
    end else begin
      pkt_done <= rec_s;
      if (rec_s) begin
        pkt_len  <= rec_len_s;
        pkt_vch  <= rec_vch_s;
        pkt_err  <= (rec_err_s != E_NONE);
        err_code <= rec_err_s;
      end
    end
  end

  // Saturating statistics counters; clr wins over any increment.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pkt_cnt    <= '0;
      err_cnt    <= '0;
      flit_cnt   <= '0;
      toggle_acc <= '0;
    end else if (clr) begin
      pkt_cnt    <= '0;
      err_cnt    <= '0;
      flit_cnt   <= '0;
      toggle_acc <= '0;
    end else begin
      if (rec_s && (rec_err_s == E_NONE) && (pkt_cnt != '1)) pkt_cnt <= pkt_cnt + CNT_ONE;
      if (rec_s && (rec_err_s != E_NONE) && (err_cnt != '1)) err_cnt <= err_cnt + CNT_ONE;
      if (accept_s && (flit_cnt != '1)) flit_cnt <= flit_cnt + CNT_ONE;
      if (accept_s) toggle_acc <= tsum_s[ACCW] ? '1 : tsum_s[ACCW-1:0];
    end
  end

endmodule

// File: tb/tb_flit_sink.sv
// Directed bench for flit_sink: expected completion records go into a queue that a
// negedge monitor drains and compares; counters are checked at quiet points.
module tb_flit_sink;

  logic        clk = 1'b0;
  logic        rst_;
  logic [65:0] idata;
  logic        ivalid;
  logic [0:0]  ivch;
  logic        clr;
  logic        busy, pkt_done, pkt_err;
  logic [7:0]  pkt_len;
  logic [0:0]  pkt_vch;
  logic [2:0]  err_code;
  logic [15:0] pkt_cnt, err_cnt, flit_cnt;
  logic [31:0] toggle_acc;

  flit_sink dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .clr(clr),
    .busy(busy), .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_vch(pkt_vch),
    .pkt_err(pkt_err), .err_code(err_code), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
    .flit_cnt(flit_cnt), .toggle_acc(toggle_acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] len;
    logic       vch;
    logic [2:0] err;
    int         cyc;
  } rec_t;

  rec_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   busy_cnt = 0;

  localparam logic [1:0] HEAD = 2'd1, DATA = 2'd2, TAIL = 2'd3, NONE = 2'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pkt_done pops one expected record.
  always @(negedge clk) begin
    rec_t e;
    if (busy) busy_cnt = busy_cnt + 1;
    if (pkt_done) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL record_unexpected: got len=%0d vch=%0d err=%0d at cycle %0d, none expected",
                 pkt_len, pkt_vch, err_code, cyc);
      end else begin
        e = exp_q.pop_front();
        if (pkt_len == e.len && pkt_vch == e.vch && err_code == e.err &&
            pkt_err == (e.err != 3'd0) && cyc == e.cyc)
          passes = passes + 1;
        else
          $display("FAIL record: got len=%0d vch=%0d err=%0d perr=%0d cyc=%0d, want len=%0d vch=%0d err=%0d cyc=%0d",
                   pkt_len, pkt_vch, err_code, pkt_err, cyc, e.len, e.vch, e.err, e.cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act === exp) passes = passes + 1;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic send(input logic [1:0] t, input logic [63:0] d, input logic v);
    @(negedge clk);
    idata  = {t, d};
    ivalid = 1'b1;
    ivch   = v;
    clr    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ivalid = 1'b0;
      idata  = '0;
      clr    = 1'b0;
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    ivalid = 1'b0;
    clr    = 1'b1;
    idle(1);
  endtask

  // Pushed at drive time: the record should appear one cycle after the flit is sampled.
  task automatic expect_rec(input logic [7:0] len, input logic vch, input logic [2:0] err);
    rec_t r;
    r.len = len; r.vch = vch; r.err = err; r.cyc = cyc + 1;
    exp_q.push_back(r);
  endtask

  initial begin
    rst_ = 1'b0; idata = '0; ivalid = 1'b0; ivch = 1'b0; clr = 1'b0;
    idle(3);
    chk("reset_busy", busy, 0);
    chk("reset_pkt_done", pkt_done, 0);
    chk("reset_pkt_len", pkt_len, 0);
    chk("reset_err_code", err_code, 0);
    chk("reset_pkt_cnt", pkt_cnt, 0);
    chk("reset_flit_cnt", flit_cnt, 0);
    chk("reset_toggle", toggle_acc, 0);
    rst_ = 1'b1;
    idle(2);

    // Normal packet
    busy_cnt = 0;
    send(HEAD, 64'd0, 1'b0);
    for (int i = 0; i < 20; i++) send(DATA, 64'd0, 1'b0);
    send(TAIL, 64'd0, 1'b0);
    expect_rec(8'd20, 1'b0, 3'd0);
    idle(4);
    chk("normal_pkt_cnt", pkt_cnt, 1);
    chk("normal_err_cnt", err_cnt, 0);
    chk("normal_flit_cnt", flit_cnt, 22);
    chk("normal_busy_cycles", busy_cnt, 22);
    chk("normal_busy_idle", busy, 0);

    // Toggle accumulation: 2 + 62 + 64
    do_clr();
    send(HEAD, 64'h9, 1'b0);
    send(DATA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(TAIL, 64'd0, 1'b0);
    expect_rec(8'd1, 1'b0, 3'd0);
    idle(2);
    chk("toggle_acc", toggle_acc, 128);
    chk("toggle_flit_cnt", flit_cnt, 3);

    // Bubbles inside packets
    do_clr();
    for (int p = 0; p < 10; p++) begin
      send(HEAD, 64'd0, 1'b0);
      for (int i = 0; i < 20; i++) begin
        if (i == 10) idle(3);
        if (i == 15) send(NONE, 64'hFF, 1'b1);
        send(DATA, 64'd0, 1'b0);
      end
      send(TAIL, 64'd0, 1'b0);
      expect_rec(8'd20, 1'b0, 3'd0);
      idle(7);
    end
    chk("bubble_pkt_cnt", pkt_cnt, 10);
    chk("bubble_err_cnt", err_cnt, 0);
    chk("bubble_flit_cnt", flit_cnt, 220);
    chk("bubble_toggle", toggle_acc, 0);

    // Nested head
    do_clr();
    send(HEAD, 64'd0, 1'b0);
    for (int i = 0; i < 3; i++) send(DATA, 64'd0, 1'b0);
    send(HEAD, 64'd0, 1'b0);
    expect_rec(8'd3, 1'b0, 3'd2);
    for (int i = 0; i < 2; i++) send(DATA, 64'd0, 1'b0);
    send(TAIL, 64'd0, 1'b0);
    expect_rec(8'd2, 1'b0, 3'd0);
    idle(2);
    chk("nested_pkt_cnt", pkt_cnt, 1);
    chk("nested_err_cnt", err_cnt, 1);
    chk("nested_flit_cnt", flit_cnt, 8);

    // Clean vch1 packet, then overlength, VCH mismatch, orphan
    do_clr();
    send(HEAD, 64'd0, 1'b1);
    send(DATA, 64'd0, 1'b1);
    send(TAIL, 64'd0, 1'b1);
    expect_rec(8'd1, 1'b1, 3'd0);
    send(HEAD, 64'd0, 1'b0);
    for (int i = 0; i < 40; i++) send(DATA, 64'd0, 1'b0);
    send(TAIL, 64'd0, 1'b0);
    expect_rec(8'd32, 1'b0, 3'd4);
    send(HEAD, 64'd0, 1'b0);
    send(DATA, 64'd0, 1'b1);
    send(TAIL, 64'd0, 1'b0);
    expect_rec(8'd1, 1'b0, 3'd3);
    idle(2);
    send(DATA, 64'd0, 1'b1);
    expect_rec(8'd0, 1'b1, 3'd1);
    idle(3);
    chk("err_pkt_cnt", pkt_cnt, 1);
    chk("err_err_cnt", err_cnt, 3);
    chk("hold_pkt_len", pkt_len, 0);
    chk("hold_err_code", err_code, 1);

    // Reset mid-packet discards it; later TAIL is an orphan
    send(HEAD, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) send(DATA, 64'd0, 1'b0);
    @(negedge clk);
    ivalid = 1'b0;
    rst_ = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    chk("reset_mid_busy", busy, 0);
    send(TAIL, 64'd0, 1'b0);
    expect_rec(8'd0, 1'b0, 3'd1);
    idle(2);
    chk("rst_flit_cnt", flit_cnt, 1);
    chk("rst_err_cnt", err_cnt, 1);
    chk("rst_pkt_cnt", pkt_cnt, 0);

    // clr together with an accepted flit; prev still updates
    send(DATA, 64'hFF, 1'b0);
    clr = 1'b1;
    expect_rec(8'd0, 1'b0, 3'd1);
    idle(1);
    chk("clr_flit_cnt", flit_cnt, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_toggle", toggle_acc, 0);
    send(DATA, 64'd0, 1'b0);
    expect_rec(8'd0, 1'b0, 3'd1);
    idle(2);
    chk("post_clr_toggle", toggle_acc, 8);
    chk("post_clr_err_cnt", err_cnt, 1);
    chk("post_clr_flit_cnt", flit_cnt, 1);

    idle(3);
    chk("records_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
